// File: rtl/param_decoder_pkg.sv
// Shared types for the parameterised code decoder: operating modes and FSM states.
package decoder_pkg;

    typedef enum logic [1:0] {
        ONEHOT = 2'd0,
        THERMO = 2'd1,
        ACCUM  = 2'd2,
        SWEEP  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam int IN_W_MIN = 1;
    localparam int IN_W_MAX = 6;

    function automatic int out_width(input int in_w);
        return 1 << in_w;
    endfunction

endpackage

// File: rtl/param_decoder_if.sv
// Code-in / decoded-out handshake bundle between a code source and the decoder.
interface param_decoder_if
    import decoder_pkg::*;
#(
    parameter int IN_W = 3
);
    localparam int OUT_W = out_width(IN_W);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    mode_e            mode;
    logic             clear;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, in_code, mode, clear,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_valid, in_code, mode, clear,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/param_decoder_code_gen.sv
// Combinational one-hot and thermometer expansion of a binary code.
module code_gen
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = out_width(IN_W)
) (
    input  logic [IN_W-1:0]  code_i,
    output logic [OUT_W-1:0] onehot_o,
    output logic [OUT_W-1:0] thermo_o
);
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
        assign onehot_o[gi] = (code_i == IN_W'(gi));
        assign thermo_o[gi] = (IN_W'(gi) <= code_i);
    end
endmodule

// File: rtl/param_decoder.sv
// Registered binary decoder with one-hot, thermometer, accumulate and sweep modes.
module param_decoder
    import decoder_pkg::*;
#(
    parameter int IN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    param_decoder_if.slave   bus
);
    localparam int OUT_W = out_width(IN_W);

    if (IN_W < IN_W_MIN || IN_W > IN_W_MAX) begin : g_bad_param
        $error("param_decoder: IN_W out of range");
    end

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] thermo;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] shift_d;
    logic             out_valid_q;
    state_e           state_q;
    logic             accept;

    code_gen #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_code_gen (
        .code_i   (bus.in_code),
        .onehot_o (onehot),
        .thermo_o (thermo)
    );

    // Ready depends only on state and clear, never on in_valid.
    assign bus.in_ready  = (state_q == ST_IDLE) && !bus.clear;
    assign accept        = bus.in_valid && bus.in_ready;
    assign shift_d       = out_q << 1;

    always_comb begin
        out_d = onehot;
        case (bus.mode)
            ONEHOT:  out_d = onehot;
            THERMO:  out_d = thermo;
            ACCUM:   out_d = out_q | onehot;
            SWEEP:   out_d = onehot;
            default: out_d = onehot;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else if (bus.clear) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else if (state_q == ST_SWEEP) begin
            out_q       <= shift_d;
            out_valid_q <= 1'b1;
            // Leave once the top bit has been reached so the sweep never wraps.
            if (shift_d[OUT_W-1]) begin
                state_q <= ST_IDLE;
            end
        end else if (accept) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
            if (bus.mode == SWEEP && !(&bus.in_code)) begin
                state_q <= ST_SWEEP;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == ST_SWEEP);

endmodule

// File: doc/param_decoder.md
PARAM_DECODER -- requirements
Module: param_decoder

Interface
REQ-001 Parameter IN_W, default 3, input code width; SHALL be 1..6.
REQ-002 Parameter OUT_W, default 2**IN_W, output width; SHALL be derived, not overridden.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  code presented.
REQ-006 in_ready  out  1  block can accept a code.
REQ-007 in  in  IN_W  binary code.
REQ-008 mode  in  2  0 one-hot, 1 thermometer, 2 accumulate, 3 sweep; sampled on accept.
REQ-009 clear  in  1  synchronous clear of output and FSM.
REQ-010 out  out  OUT_W  registered decoded value.
REQ-011 out_valid  out  1  out updated this cycle.
REQ-012 busy  out  1  sweep in progress.

Function
REQ-013 An accept SHALL occur on a clock edge with in_valid=1, in_ready=1.
REQ-014 in_ready SHALL be 1 in IDLE with clear=0, else 0; no combinational path from in_valid to in_ready.
REQ-015 Latency SHALL be one cycle: out and out_valid reflect an accept on the next cycle.
REQ-016 Mode 0: out SHALL become 1<<in.
REQ-017 Mode 1: out SHALL become bits 0..in set, all others 0 (in=0 -> 0x01, in=IN_W max -> all ones).
REQ-018 Mode 2: out SHALL become out OR (1<<in); repeated codes SHALL be idempotent.
REQ-019 Mode 3: out SHALL become 1<<in; if in<OUT_W-1 the FSM SHALL enter SWEEP, else stay IDLE.
REQ-020 FSM states SHALL be IDLE and SWEEP only.
REQ-021 In SWEEP each cycle out SHALL shift left by one with out_valid=1; after the shift that sets bit OUT_W-1 the FSM SHALL return to IDLE.
REQ-022 A sweep from code k SHALL produce exactly OUT_W-k consecutive out_valid beats, no wrap to bit 0.
REQ-023 busy SHALL equal (state==SWEEP).
REQ-024 out_valid SHALL be 0 in any cycle not following an accept or a SWEEP shift; out SHALL hold its value.
REQ-025 clear SHALL have priority over accept and sweep: next cycle out=0, out_valid=0, state IDLE.
REQ-026 Invalid mode codes do not exist (2 bits fully decoded); no X SHALL propagate from unused bits.

Reset
REQ-027 reset SHALL asynchronously force out=0, out_valid=0, busy=0, state IDLE; in_ready=1 after release.
REQ-028 reset asserted mid-sweep SHALL abort the sweep with no further out_valid beats.

Structure
REQ-029 Package decoder_pkg SHALL hold the mode enumeration (ONEHOT, THERMO, ACCUM, SWEEP) and the FSM state type.
REQ-030 Combinational sub-module code_gen SHALL produce one-hot and thermometer vectors from in; param_decoder SHALL hold all registers and the FSM.

Verification
REQ-031 IN_W=3, mode 0, in=5 -> next cycle out=0x20, out_valid=1 for one cycle; in=0 -> 0x01.
REQ-032 Mode 1, in=3 -> out=0x0F; in=7 -> out=0xFF.
REQ-033 Mode 2, in=1 then in=6 then in=1 -> out 0x02, 0x42, 0x42.
REQ-034 Mode 3, in=5 -> out 0x20, 0x40, 0x80 on three consecutive beats, busy high for two cycles, in_ready low during sweep, held in_valid accepted only after return to IDLE; in=7 -> single beat 0x80, busy never high.
REQ-035 clear asserted during mode-3 sweep from in=2 after out=0x08 -> next cycle out=0, out_valid=0, busy=0; clear with in_valid=1 -> no accept.
REQ-036 reset pulsed asynchronously (between edges) mid-sweep -> out=0, busy=0 immediately; IN_W=1 and IN_W=6 builds pass REQ-031 boundaries.
